pool_requant_fifo: RTL and testbench

//  Downstream stage of the conv3x3/ReLU/maxpool2x2 Top. Takes each 15-bit max-pool result
//  as it is produced and requantizes it to 8 bits. Buffers the results in a FIFO and streams

---
 rtl/pool_requant_fifo_pkg.sv | 42 ++++
 rtl/pool_requant_fifo_if.sv | 34 +++
 rtl/pool_requant_fifo_sync_fifo.sv | 56 +++++
 rtl/pool_requant_fifo.sv | 107 ++++++++++
 tb/tb_pool_requant_fifo.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_requant_fifo_pkg.sv
// ============================================================================
// Package   : cnn_pkg
// Purpose   : Shared widths, per-layer pooled-map sizes and shifts, and the
//             requantization function used by the pool requant stage.
// Config    : POOL_REQUANT_ROUND_EN selects round-half-up in requant().
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int IN_W        = 15;
    localparam int OUT_W       = 8;

    localparam int MAP_SIDE_L0 = 12;
    localparam int MAP_SIDE_L1 = 5;
    localparam int MAP_PIX_L0  = MAP_SIDE_L0 * MAP_SIDE_L0;
    localparam int MAP_PIX_L1  = MAP_SIDE_L1 * MAP_SIDE_L1;

    localparam int SHIFT_L0    = 7;
    localparam int SHIFT_L1    = 7;

    localparam int FIFO_DEPTH  = 16;

    // Unsigned shift-and-saturate; the intermediate is one bit wider than the
    // input so the rounding add cannot wrap.
    function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] d, input int shift);
        logic [IN_W:0] w_t;
        w_t = {1'b0, d};
`ifdef POOL_REQUANT_ROUND_EN
        w_t = w_t + (IN_W+1)'(1 << (shift - 1));
`endif
        w_t = w_t >> shift;
        if (w_t > (IN_W+1)'((1 << OUT_W) - 1)) begin
            return '1;
        end
        return w_t[OUT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_requant_fifo_if.sv
// ============================================================================
// Interface : pool_requant_fifo_if
// Purpose   : Pooled-value input and requantized valid/ready output bundle.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pool_requant_fifo_if #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 8,
    parameter int LVL_W = 5
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             frame_done;
    logic             overflow;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, frame_done, overflow, level
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, frame_done, overflow, level
    );
endinterface

`default_nettype wire

// File: rtl/pool_requant_fifo_sync_fifo.sv
// ============================================================================
// Module    : sync_fifo
// Purpose   : Single-clock FIFO with extra-MSB pointers; push and pop at full
//             in the same cycle are both accepted.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/pool_requant_fifo.sv
// ============================================================================
// Module    : pool_requant_fifo
// Purpose   : Requantizes pooled values to OUT_W bits, buffers them and
//             streams them out with a last-pixel tag per map.
// Config    : POOL_REQUANT_ROUND_EN enables round-half-up before the shift.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_requant_fifo
    import cnn_pkg::*;
#(
    parameter int IN_W    = cnn_pkg::IN_W,
    parameter int OUT_W   = cnn_pkg::OUT_W,
    parameter int SHIFT   = cnn_pkg::SHIFT_L0,
    parameter int DEPTH   = cnn_pkg::FIFO_DEPTH,
    parameter int MAP_PIX = cnn_pkg::MAP_PIX_L0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pool_requant_fifo_if.slave bus
);
    localparam int SUM_W = IN_W + 1;
    localparam int CNT_W = (MAP_PIX > 1) ? $clog2(MAP_PIX) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [SUM_W-1:0] c_MAX_Q = SUM_W'((1 << OUT_W) - 1);

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_shr;
    logic [OUT_W-1:0] w_q;
    logic             w_at_last;

    logic             r_s1_valid;
    logic [OUT_W-1:0] r_s1_q;
    logic             r_s1_last;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             r_overflow;
    logic             r_frame_done;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [OUT_W:0]   w_head;
    logic [LVL_W-1:0] w_level;

`ifdef POOL_REQUANT_ROUND_EN
    localparam logic [SUM_W-1:0] c_HALF = SUM_W'(1 << (SHIFT - 1));
    assign w_sum = {1'b0, bus.in_data} + c_HALF;
`else
    assign w_sum = {1'b0, bus.in_data};
`endif
    assign w_shr     = w_sum >> SHIFT;
    assign w_q       = (w_shr > c_MAX_Q) ? '1 : w_shr[OUT_W-1:0];
    assign w_at_last = (r_pix_cnt == CNT_W'(MAP_PIX - 1));

    // A staged entry may enter a full FIFO only when the head leaves this cycle.
    assign w_pop  = !w_empty && bus.out_ready;
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_q       <= '0;
            r_s1_last    <= 1'b0;
            r_pix_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_q    <= w_q;
                r_s1_last <= w_at_last;
                r_pix_cnt <= w_at_last ? '0 : r_pix_cnt + 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
            r_frame_done <= w_pop && w_head[OUT_W];
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_s1_last, r_s1_q}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_empty ? '0 : w_head[OUT_W-1:0];
    assign bus.out_last   = !w_empty && w_head[OUT_W];
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;
    assign bus.level      = w_level;

endmodule

`default_nettype wire

// File: tb/tb_pool_requant_fifo.sv
// ============================================================================
// Module    : tb_pool_requant_fifo
// Purpose   : Directed self-checking bench for pool_requant_fifo.
// Config    : POOL_REQUANT_ROUND_EN switches the expected requant constants.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_requant_fifo;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pool_requant_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LVL_W(5)) bus ();

    pool_requant_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Pushes one value into an empty pipeline and returns the first output seen.
    task automatic send_and_get(input logic [14:0] d, output logic [7:0] q, output logic ok);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8 && !bus.out_valid; i++) step();
        ok = bus.out_valid;
        q = bus.out_data;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 15'h0080;
        bus.out_ready = 1'b1;
        repeat (2) step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_requant();
        logic [14:0] vin  [5];
        logic [7:0]  vexp [5];
        logic [7:0]  q;
        logic        ok;
        do_reset();
        // Latency: captured at the first edge, visible after the second.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 15'h0080;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", bus.out_valid); end
        step();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 8'h01) begin bad++; $display("FAIL latency_data got=%0h exp=1", bus.out_data); end
        step();
        vin = '{15'h0080, 15'h00C0, 15'h0000, 15'h003F, 15'h0040};
`ifdef POOL_REQUANT_ROUND_EN
        vexp = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h01};
`else
        vexp = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
`endif
        for (int i = 0; i < 5; i++) begin
            send_and_get(vin[i], q, ok);
            total++; if (ok !== 1'b1 || q !== vexp[i]) begin bad++; $display("FAIL requant_%0h got=%0h valid=%b exp=%0h", vin[i], q, ok, vexp[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [14:0] vin  [3];
        logic [7:0]  vexp [3];
        logic [7:0]  q;
        logic        ok;
        vin = '{15'h7FFF, 15'h7F7F, 15'h7F80};
`ifdef POOL_REQUANT_ROUND_EN
        vexp = '{8'hFF, 8'hFF, 8'hFF};
`else
        vexp = '{8'hFF, 8'hFE, 8'hFF};
`endif
        for (int i = 0; i < 3; i++) begin
            send_and_get(vin[i], q, ok);
            total++; if (ok !== 1'b1 || q !== vexp[i]) begin bad++; $display("FAIL saturate_%0h got=%0h valid=%b exp=%0h", vin[i], q, ok, vexp[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 15'(k << 7);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL bp_level got=%0d exp=16", bus.level); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b exp=1", bus.overflow); end
        step();
        total++; if (bus.out_data !== 8'd1) begin bad++; $display("FAIL bp_head_stable got=%0d exp=1", bus.out_data); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(k)) begin bad++; $display("FAIL bp_order got=%0d valid=%b exp=%0d", bus.out_data, bus.out_valid, k); end
            step();
        end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_dropped_absent got=%b exp=0", bus.out_valid); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_sticky got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_frame();
        int   n;
        int   fd;
        logic prev_last;
        do_reset();
        bus.out_ready = 1'b1;
        n = 0;
        fd = 0;
        prev_last = 1'b0;
        fork
            begin
                for (int k = 0; k < 145; k++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data = 15'(k << 7);
                    step();
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && n < 145; c++) begin
                    step();
                    if (bus.frame_done) begin
                        fd++;
                        total++; if (prev_last !== 1'b1) begin bad++; $display("FAIL frame_done_timing got=1 exp=0 at out %0d", n); end
                    end
                    prev_last = bus.out_valid && bus.out_last;
                    if (bus.out_valid) begin
                        total++; if (bus.out_last !== (n == 143)) begin bad++; $display("FAIL frame_last got=%b exp=%b at out %0d", bus.out_last, (n == 143), n); end
                        total++; if (bus.out_data !== requant(15'(n << 7), SHIFT_L0)) begin bad++; $display("FAIL frame_data got=%0d exp=%0d", bus.out_data, n); end
                        n++;
                    end
                end
            end
        join
        total++; if (n !== 145) begin bad++; $display("FAIL frame_count got=%0d exp=145", n); end
        total++; if (fd !== 1) begin bad++; $display("FAIL frame_done_pulses got=%0d exp=1", fd); end
    endtask

    task automatic test_full_simul();
        int exp_v;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 15'(k << 7);
            step();
        end
        total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL fs_level_full got=%0d exp=16", bus.level); end
        bus.out_ready = 1'b1;
        exp_v = 1;
        for (int c = 0; c < 40 && exp_v <= 20; c++) begin
            if (c < 3) begin
                bus.in_valid = 1'b1;
                bus.in_data = 15'((18 + c) << 7);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (c < 5) begin
                total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL fs_level got=%0d exp=16 cycle %0d", bus.level, c); end
            end
            if (bus.out_valid) begin
                total++; if (bus.out_data !== 8'(exp_v)) begin bad++; $display("FAIL fs_order got=%0d exp=%0d", bus.out_data, exp_v); end
                exp_v++;
            end
            step();
        end
        total++; if (exp_v !== 21) begin bad++; $display("FAIL fs_count got=%0d exp=21", exp_v - 1); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fs_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        int n;
        int lasts;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 15'(k << 7);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL rm_pre_overflow got=%b exp=1", bus.overflow); end
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        total++; if (bus.level !== 5'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_flushed got=%0d exp=0", bus.level); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rm_overflow got=%b exp=0", bus.overflow); end
        bus.out_ready = 1'b1;
        n = 0;
        lasts = 0;
        fork
            begin
                for (int k = 0; k < 144; k++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data = 15'(k << 7);
                    step();
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && n < 144; c++) begin
                    step();
                    if (bus.out_valid) begin
                        if (bus.out_last) lasts++;
                        total++; if (bus.out_last !== (n == 143)) begin bad++; $display("FAIL rm_last got=%b exp=%b at out %0d", bus.out_last, (n == 143), n); end
                        n++;
                    end
                end
            end
        join
        total++; if (n !== 144 || lasts !== 1) begin bad++; $display("FAIL rm_count got=%0d lasts=%0d exp=144 lasts=1", n, lasts); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_requant();
        test_saturation();
        test_backpressure();
        test_frame();
        test_full_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
